// File: rtl/kn_coloring_check_seq.sv
// Sequential K_N colouring checker: one shared colour comparator walks all vertex
// pairs in lexicographic order and reports a proper/improper verdict with the first conflict.
module kn_coloring_check_seq #(
    parameter int unsigned N_VERT     = 5,
    parameter int unsigned COLOR_W    = 3,
    parameter int unsigned EARLY_EXIT = 1,
    localparam int unsigned IDX_W     = (N_VERT > 1) ? $clog2(N_VERT) : 1,
    localparam int unsigned P         = N_VERT * (N_VERT - 1) / 2,
    localparam int unsigned CNT_W     = $clog2(P + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [N_VERT*COLOR_W-1:0] colors,
    output logic                      busy,
    output logic                      done,
    output logic                      proper,
    output logic [IDX_W-1:0]          conflict_i,
    output logic [IDX_W-1:0]          conflict_j,
    output logic [CNT_W-1:0]          pair_count
);

    localparam bit EXIT_EARLY = (EARLY_EXIT != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [N_VERT*COLOR_W-1:0] colors_q, colors_d;
    logic [IDX_W-1:0]          i_q, i_d;
    logic [IDX_W-1:0]          j_q, j_d;
    logic [IDX_W-1:0]          ci_q, ci_d;
    logic [IDX_W-1:0]          cj_q, cj_d;
    logic [CNT_W-1:0]          pc_q, pc_d;
    logic                      flag_q, flag_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      proper_q, proper_d;

    logic [COLOR_W-1:0]        col [N_VERT];
    logic                      match_c;
    logic                      hit_c;
    logic                      last_c;

    // Unpack the latched colouring so the comparator can index vertices directly.
    for (genvar v = 0; v < N_VERT; v++) begin : g_unpack
        assign col[v] = colors_q[v*COLOR_W +: COLOR_W];
    end

    assign match_c = (col[i_q] == col[j_q]);
    assign hit_c   = match_c && !flag_q;
    assign last_c  = (i_q == IDX_W'(N_VERT - 2)) && (j_q == IDX_W'(N_VERT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            colors_q <= '0;
            i_q      <= '0;
            j_q      <= '0;
            ci_q     <= '0;
            cj_q     <= '0;
            pc_q     <= '0;
            flag_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            proper_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            colors_q <= colors_d;
            i_q      <= i_d;
            j_q      <= j_d;
            ci_q     <= ci_d;
            cj_q     <= cj_d;
            pc_q     <= pc_d;
            flag_q   <= flag_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            proper_q <= proper_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        colors_d = colors_q;
        i_d      = i_q;
        j_d      = j_q;
        ci_d     = ci_q;
        cj_d     = cj_q;
        pc_d     = pc_q;
        flag_d   = flag_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        proper_d = proper_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    colors_d = colors;
                    i_d      = '0;
                    j_d      = IDX_W'(1);
                    ci_d     = '0;
                    cj_d     = '0;
                    pc_d     = '0;
                    flag_d   = 1'b0;
                    proper_d = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = S_SCAN;
                end
            end
            S_SCAN: begin
                pc_d = pc_q + CNT_W'(1);
                if (hit_c) begin
                    ci_d   = i_q;
                    cj_d   = j_q;
                    flag_d = 1'b1;
                end
                // The pair indices are left untouched on exit so they never pass N_VERT-1.
                if (last_c || (EXIT_EARLY && hit_c)) begin
                    done_d   = 1'b1;
                    proper_d = !(flag_q || hit_c);
                    state_d  = S_DONE;
                end else begin
                    busy_d = 1'b1;
                    if (j_q == IDX_W'(N_VERT - 1)) begin
                        i_d = i_q + IDX_W'(1);
                        j_d = i_q + IDX_W'(2);
                    end else begin
                        j_d = j_q + IDX_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign proper     = proper_q;
    assign conflict_i = ci_q;
    assign conflict_j = cj_q;
    assign pair_count = pc_q;

endmodule

// File: tb/tb_kn_coloring_check_seq.sv
// Directed bench for kn_coloring_check_seq: an early-exit and a full-scan instance
// share stimulus; verdicts and timings are checked against hand-computed values.
module tb_kn_coloring_check_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [14:0] colors;

    logic        busy_a, done_a, proper_a;
    logic [2:0]  ci_a, cj_a;
    logic [3:0]  pc_a;
    logic        busy_b, done_b, proper_b;
    logic [2:0]  ci_b, cj_b;
    logic [3:0]  pc_b;

    int checks = 0;
    int errors = 0;

    int          dc_a, dc_b, nb_a;
    logic        pr_a, pr_b;
    logic [2:0]  ci_ra, cj_ra, ci_rb, cj_rb;
    logic [3:0]  pc_ra, pc_rb;

    kn_coloring_check_seq #(.N_VERT(5), .COLOR_W(3), .EARLY_EXIT(1)) dut_a (
        .clk(clk), .rst(rst), .start(start), .colors(colors),
        .busy(busy_a), .done(done_a), .proper(proper_a),
        .conflict_i(ci_a), .conflict_j(cj_a), .pair_count(pc_a)
    );

    kn_coloring_check_seq #(.N_VERT(5), .COLOR_W(3), .EARLY_EXIT(0)) dut_b (
        .clk(clk), .rst(rst), .start(start), .colors(colors),
        .busy(busy_b), .done(done_b), .proper(proper_b),
        .conflict_i(ci_b), .conflict_j(cj_b), .pair_count(pc_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [14:0] pack(input int v0, input int v1, input int v2,
                                         input int v3, input int v4);
        return {3'(v4), 3'(v3), 3'(v2), 3'(v1), 3'(v0)};
    endfunction

    // Cycle n = interval ending at edge n; the start sample edge is edge 0.
    task automatic run(input logic [14:0] col);
        colors = col;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dc_a = 0; dc_b = 0; nb_a = 0;
        for (int cyc = 1; cyc <= 40 && (dc_a == 0 || dc_b == 0); cyc++) begin
            if (busy_a) nb_a++;
            if (done_a && dc_a == 0) begin
                dc_a = cyc; pr_a = proper_a; ci_ra = ci_a; cj_ra = cj_a; pc_ra = pc_a;
            end
            if (done_b && dc_b == 0) begin
                dc_b = cyc; pr_b = proper_b; ci_rb = ci_b; cj_rb = cj_b; pc_rb = pc_b;
            end
            @(posedge clk); #1;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic verdict(input string tag,
                           input int da, input int pa, input int ia, input int ja, input int ca,
                           input int db, input int pb, input int ib, input int jb, input int cb);
        chk({tag, "_a_done_cycle"}, 32'(dc_a), 32'(da));
        chk({tag, "_a_proper"},     32'(pr_a), 32'(pa));
        chk({tag, "_a_ci"},         32'(ci_ra), 32'(ia));
        chk({tag, "_a_cj"},         32'(cj_ra), 32'(ja));
        chk({tag, "_a_pc"},         32'(pc_ra), 32'(ca));
        chk({tag, "_b_done_cycle"}, 32'(dc_b), 32'(db));
        chk({tag, "_b_proper"},     32'(pr_b), 32'(pb));
        chk({tag, "_b_ci"},         32'(ci_rb), 32'(ib));
        chk({tag, "_b_cj"},         32'(cj_rb), 32'(jb));
        chk({tag, "_b_pc"},         32'(pc_rb), 32'(cb));
        chk({tag, "_a_hold_proper"}, 32'(proper_a), 32'(pa));
        chk({tag, "_a_hold_pc"},     32'(pc_a), 32'(ca));
        chk({tag, "_b_hold_ci"},     32'(ci_b), 32'(ib));
    endtask

    initial begin
        int d1, d2, saw;
        logic p1, p2;

        rst = 1'b1; start = 1'b0; colors = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",   32'(busy_a), 0);
        chk("rst_done",   32'(done_a), 0);
        chk("rst_proper", 32'(proper_a), 0);
        chk("rst_pc",     32'(pc_a), 0);
        chk("rst_ci",     32'(ci_a), 0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_no_start_busy", 32'(busy_a | busy_b), 0);

        // All distinct: full scan on both instances.
        run(pack(0, 1, 2, 3, 4));
        verdict("distinct", 11, 1, 0, 0, 10, 11, 1, 0, 0, 10);
        chk("distinct_busy_cycles", 32'(nb_a), 10);

        // All the same colour.
        run(pack(5, 5, 5, 5, 5));
        verdict("allsame", 2, 0, 0, 1, 1, 11, 0, 0, 1, 10);

        // Only the very last pair conflicts.
        run(pack(0, 1, 2, 5, 5));
        verdict("lastpair", 11, 0, 3, 4, 10, 11, 0, 3, 4, 10);

        // Two conflicts; the first one must stick.
        run(pack(1, 2, 1, 2, 7));
        verdict("twoconf", 3, 0, 0, 2, 2, 11, 0, 0, 2, 10);

        // Start held high, colours changing every cycle.
        colors = pack(0, 1, 2, 3, 4);
        start  = 1'b1;
        @(posedge clk); #1;
        d1 = 0; d2 = 0; p1 = 1'b0; p2 = 1'b0;
        for (int cyc = 1; cyc <= 40 && d2 == 0; cyc++) begin
            if (done_a) begin
                if (d1 == 0) begin
                    d1 = cyc; p1 = proper_a;
                end else begin
                    d2 = cyc; p2 = proper_a;
                    start = 1'b0;
                end
            end
            colors = (cyc == 12) ? pack(4, 3, 2, 1, 0) : {5{3'(cyc)}};
            @(posedge clk); #1;
        end
        chk("held_first_done",   32'(d1), 11);
        chk("held_first_proper", 32'(p1), 1);
        chk("held_second_done",  32'(d2), 23);
        chk("held_second_proper", 32'(p2), 1);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("held_released_idle", 32'(busy_a | busy_b), 0);

        // Reset in cycle 5 of a scan.
        colors = pack(0, 1, 2, 5, 5);
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_pc",   32'(pc_a), 4);
        chk("pre_rst_busy", 32'(busy_a), 1);
        rst = 1'b1;
        #1;
        chk("midrst_busy",   32'(busy_a | busy_b), 0);
        chk("midrst_done",   32'(done_a | done_b), 0);
        chk("midrst_proper", 32'(proper_a | proper_b), 0);
        chk("midrst_pc",     32'(pc_a), 0);
        chk("midrst_ci_cj",  32'({ci_a, cj_a}), 0);
        saw = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done_a || done_b) saw++;
        end
        rst = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done_a || done_b) saw++;
        end
        chk("midrst_no_done", 32'(saw), 0);
        run(pack(4, 0, 3, 1, 2));
        verdict("after_rst", 11, 1, 0, 0, 10, 11, 1, 0, 0, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/kn_coloring_check_seq.md
Name: kn_coloring_check_seq

Overview:
- Sequential, resource-shared checker for a proposed vertex colouring of the complete graph K_N.
- Uses one COLOR_W-bit equality comparator, reused across all N(N-1)/2 vertex pairs.
- Pairs are walked in lexicographic order; the block reports a proper/improper verdict plus the first conflicting pair.
- Sits beside the flat combinational K_N colouring checkers and replaces them where area matters more than latency.

Parameters:
- N_VERT, 5, number of vertices (N_VERT >= 2).
- COLOR_W, 3, bits per vertex colour.
- EARLY_EXIT, 1, 1 = stop at first conflict; 0 = always scan every pair.
- Derived localparams: IDX_W = clog2(N_VERT); P = N_VERT*(N_VERT-1)/2; CNT_W = clog2(P+1).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a check; sampled only in IDLE.
- colors  input  N_VERT*COLOR_W  flat colouring; vertex v occupies bits [v*COLOR_W +: COLOR_W].
- busy  output  1  high while in SCAN.
- done  output  1  one-cycle pulse when the verdict is valid.
- proper  output  1  1 = no two vertices share a colour.
- conflict_i  output  IDX_W  lower vertex index of the first conflicting pair.
- conflict_j  output  IDX_W  higher vertex index of the first conflicting pair.
- pair_count  output  CNT_W  number of pairs compared in the last check.

Behaviour:
- Reset (asynchronous, takes effect immediately, any state): state=IDLE; busy, done, proper, conflict_i, conflict_j, pair_count and internal i, j, conflict flag and colour register all 0.
- States: IDLE, SCAN, DONE.
- IDLE, start=1 at a rising edge:
  - latch colors into an internal register;
  - set i=0, j=1, pair_count=0, clear conflict flag, proper=0;
  - go to SCAN.
  - start=0: stay in IDLE; outputs hold their last verdict.
- SCAN: exactly one pair (i,j) is compared per cycle, using the latched colours only. The colors input is ignored after latch.
  - Each cycle pair_count increments.
  - If the colours match and no conflict is recorded yet: record conflict_i=i, conflict_j=j and set the flag.
  - Pair advance: if j==N_VERT-1 then i<=i+1, j<=i+2; else j<=j+1.
  - Go to DONE when the last pair (N_VERT-2, N_VERT-1) has been compared.
  - With EARLY_EXIT=1, also go to DONE in the same cycle a conflict is found.
- DONE: done=1 for exactly one cycle; proper = !flag; busy=0; next state is IDLE.
  - If no conflict: conflict_i and conflict_j stay 0.
- Timing, with the start sample edge at cycle 0:
  - pair q (0-based lexicographic index) is compared in cycle q+1;
  - full scan: busy in cycles 1..P, done in cycle P+1 (cycle 11 for N_VERT=5);
  - early exit at pair q: done in cycle q+2, pair_count=q+1.
- start is ignored in SCAN and DONE. There is no queueing: a start held high re-triggers only once state is back in IDLE, i.e. the cycle after done.
- Verdict outputs (proper, conflict_i, conflict_j, pair_count) are stable from DONE until the next accepted start.
- Width rules: i and j never exceed N_VERT-1. pair_count saturates naturally at P and never wraps.
- Reset mid-SCAN aborts with no done pulse. The next start behaves as from power-up.

Test Plan:
- N_VERT=5, colors = {4,3,2,1,0} (v0=0..v4=4), start pulse -> busy cycles 1..10; done in cycle 11; proper=1; pair_count=10; conflict_i=conflict_j=0.
- All vertices colour 5, EARLY_EXIT=1 -> done in cycle 2; proper=0; conflict=(0,1); pair_count=1.
- Colours v0..v4 = 0,1,2,5,5, EARLY_EXIT=1 -> conflict=(3,4) found at pair 9; done in cycle 11; pair_count=10; proper=0.
- EARLY_EXIT=0, colours 1,2,1,2,7 (v0=v2, v1=v3) -> first conflict (0,2) reported; (1,3) does not overwrite it; pair_count=10; done in cycle 11.
- Hold start=1 continuously and change colors every cycle during SCAN -> the verdict matches the colouring latched at the first start. The second check is accepted at cycle 12 and gives done at cycle 23.
- Assert rst in cycle 5 of a scan -> all outputs 0 immediately, no done pulse. A following start with distinct colours gives proper=1 after P+1 cycles.
